// File: rtl/timestep_scheduler_pkg.sv
// Shared types and constants for the timestep scheduler.
// Sequencer state encodings and the CIM state codes it observes.
package timestep_scheduler_pkg;

   localparam int NUMWIDTH_DEF = 16;
   localparam int TAGBITS_DEF  = 6;
   localparam int NRN_LAT_DEF  = 4;
   localparam int STEPBITS_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UPDATE,
      ST_FLUSH,
      ST_DRAIN,
      ST_SWAP_REQ,
      ST_SWAP_WAIT
   } sched_state_e;

   typedef enum logic [1:0] {
      CIM_WAIT_TAG       = 2'b00,
      CIM_FETCH_WEIGHT   = 2'b01,
      CIM_COMPUTE_I_NEXT = 2'b11,
      CIM_SWAP           = 2'b10
   } cim_state_e;

   // Spikes arriving once the sweep has flushed belong to a finished sweep.
   function automatic logic is_late_state(sched_state_e s);
      return (s == ST_DRAIN) || (s == ST_SWAP_REQ) || (s == ST_SWAP_WAIT);
   endfunction

endpackage

// File: rtl/timestep_scheduler_tag_fifo.sv
// Show-ahead, count-based FIFO of fired neuron tags.
// A push on a full FIFO is only accepted when a pop frees a slot the same cycle.
module tag_fifo
   import timestep_scheduler_pkg::*;
#(
   parameter int width = TAGBITS_DEF,
   parameter int depth = 2 ** TAGBITS_DEF
) (
   input  logic             clk,
   input  logic             asyn_reset,
   input  logic             push_i,
   input  logic [width-1:0] data_i,
   input  logic             pop_i,
   output logic [width-1:0] head_o,
   output logic             empty_o,
   output logic             drop_o
);

   localparam int AW = (depth > 1) ? $clog2(depth) : 1;
   localparam int CW = $clog2(depth + 1);
   localparam logic [AW-1:0] PTR_LAST = AW'(depth - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(depth);

   logic [width-1:0] mem_q [depth];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_pop;
   logic             do_push;

   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && ((cnt_q != CNT_FULL) || do_pop);
   assign drop_o  = push_i && !do_push;

   // Advance pointers with wrap and track occupancy.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge asyn_reset) begin
      if (asyn_reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Tag storage; contents are only observed while not empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/timestep_scheduler.sv
// Sequences one timestep: current sweep, flush, spike drain, swap.
// Fired tags are buffered for CIM in a show-ahead FIFO.
module timestep_scheduler
   import timestep_scheduler_pkg::*;
#(
   parameter int numwidth    = NUMWIDTH_DEF,
   parameter int tagbits     = TAGBITS_DEF,
   parameter int numneurons  = 2 ** tagbits,
   parameter int nrn_latency = NRN_LAT_DEF,
   parameter int stepbits    = STEPBITS_DEF
) (
   input  logic                clk,
   input  logic                asyn_reset,
   input  logic                step_req,
   output logic                step_done,
   output logic [stepbits-1:0] step_count,
   output logic [tagbits-1:0]  i_tag,
   input  logic [numwidth:0]   i_in,
   output logic                nrn_i_valid,
   output logic [tagbits-1:0]  nrn_tag,
   output logic [numwidth:0]   nrn_i,
   input  logic                spike_valid,
   input  logic [tagbits-1:0]  spike_tag,
   output logic [tagbits-1:0]  fired_tag,
   output logic                fifo_empty,
   input  logic                req_deq,
   input  logic                cim_busy,
   input  logic [1:0]          cim_state,
   output logic                swap,
   output logic                overflow,
   output logic                late_spike
);

   localparam int FW = $clog2(nrn_latency + 2);
   localparam logic [tagbits-1:0] TAG_LAST = tagbits'(numneurons - 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(nrn_latency);

   sched_state_e        state_q, state_d;
   logic [tagbits-1:0]  tag_q, tag_d;
   logic [FW-1:0]       flush_q, flush_d;
   logic                seen_q, seen_d;
   logic                done_q, done_d;
   logic [stepbits-1:0] steps_q, steps_d;
   logic                nvalid_q, nvalid_d;
   logic [tagbits-1:0]  ntag_q, ntag_d;
   logic                ovf_q, ovf_d;
   logic                late_q, late_d;
   logic                drop;

   tag_fifo #(
      .width (tagbits),
      .depth (numneurons)
   ) u_fifo (
      .clk        (clk),
      .asyn_reset (asyn_reset),
      .push_i     (spike_valid),
      .data_i     (spike_tag),
      .pop_i      (req_deq),
      .head_o     (fired_tag),
      .empty_o    (fifo_empty),
      .drop_o     (drop)
   );

   assign step_done   = done_q;
   assign step_count  = steps_q;
   assign i_tag       = tag_q;
   assign nrn_i_valid = nvalid_q;
   assign nrn_tag     = ntag_q;
   assign nrn_i       = i_in;
   assign overflow    = ovf_q;
   assign late_spike  = late_q;

   // Next-state logic, swap strobe and sticky error flags.
   always_comb begin
      state_d  = state_q;
      tag_d    = tag_q;
      flush_d  = flush_q;
      seen_d   = seen_q;
      done_d   = 1'b0;
      steps_d  = steps_q;
      swap     = 1'b0;
      nvalid_d = (state_q == ST_UPDATE);
      ntag_d   = tag_q;
      ovf_d    = ovf_q | drop;
      late_d   = late_q | (spike_valid && is_late_state(state_q));
      unique case (state_q)
         ST_IDLE: begin
            if (step_req) begin
               state_d = ST_UPDATE;
               tag_d   = '0;
            end
         end
         ST_UPDATE: begin
            tag_d = (tag_q == TAG_LAST) ? '0 : tag_q + 1'b1;
            if (tag_q == TAG_LAST) begin
               state_d = ST_FLUSH;
               flush_d = '0;
            end
         end
         ST_FLUSH: begin
            if (flush_q == FLUSH_LAST) state_d = ST_DRAIN;
            else flush_d = flush_q + 1'b1;
         end
         ST_DRAIN: begin
            if (fifo_empty && !spike_valid && !cim_busy)
               state_d = ST_SWAP_REQ;
         end
         ST_SWAP_REQ: begin
            swap    = 1'b1;
            seen_d  = 1'b0;
            state_d = ST_SWAP_WAIT;
         end
         ST_SWAP_WAIT: begin
            if (cim_state == CIM_SWAP) seen_d = 1'b1;
            if (seen_q && !cim_busy) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               steps_d = steps_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer registers.
   always_ff @(posedge clk or posedge asyn_reset) begin
      if (asyn_reset) begin
         state_q  <= ST_IDLE;
         tag_q    <= '0;
         flush_q  <= '0;
         seen_q   <= 1'b0;
         done_q   <= 1'b0;
         steps_q  <= '0;
         nvalid_q <= 1'b0;
         ntag_q   <= '0;
         ovf_q    <= 1'b0;
         late_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         flush_q  <= flush_d;
         seen_q   <= seen_d;
         done_q   <= done_d;
         steps_q  <= steps_d;
         nvalid_q <= nvalid_d;
         ntag_q   <= ntag_d;
         ovf_q    <= ovf_d;
         late_q   <= late_d;
      end
   end

endmodule
